turf_painter: RTL and testbench

- Downstream of the per-tick player mover.
- On each game tick it snapshots the four 18-bit player records and visits each active player in order p1..p4.
- For each player it reads the 3-bit cell at the player's head from the 160x120 turf RAM. An occupied cell or an off-board head kills the player; otherwise it paints the player's colour into RAM and mirrors the pixel to the VGA plotter.
- After reset it clears the whole board.

---
 rtl/turf_painter.sv | 219 +++++++++++++++++++++
 tb/tb_turf_painter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_painter.sv
// Per-tick turf painter: clears the 160x120 board after reset, then on each
// tick checks each active player's head cell, killing or painting it.
module turf_painter #(
  parameter int         W      = 160,
  parameter int         H      = 120,
  parameter int         RD_LAT = 2,
  parameter logic [2:0] C1     = 3'b100,
  parameter logic [2:0] C2     = 3'b010,
  parameter logic [2:0] C3     = 3'b001,
  parameter logic [2:0] C4     = 3'b110
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        tick,
  input  logic [71:0] players,
  input  logic        clear_req,
  output logic [14:0] ram_address,
  output logic [2:0]  ram_data,
  output logic        ram_wren,
  input  logic [2:0]  ram_q,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [3:0]  kill,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {CLEAR, IDLE, SEL, RD, WAIT, CHK, WR} state_t;

  localparam logic [8:0] WL = 9'(W);
  localparam logic [7:0] HL = 8'(H);

  state_t          state, state_n;
  logic [7:0]      cx, cx_n;
  logic [6:0]      cy, cy_n;
  logic            clr_end, clr_end_n;
  logic [3:0][17:0] snap, snap_n;
  logic [1:0]      idx, idx_n;
  logic [7:0]      wcnt, wcnt_n;
  logic [14:0]     addr_n;
  logic [2:0]      data_n, col_n;
  logic [7:0]      vx_n;
  logic [6:0]      vy_n;
  logic [3:0]      kill_n;
  logic            wren_n, plot_n, busy_n, done_n, ovr_n, next_p;

  logic [17:0] cur;
  logic [7:0]  px;
  logic [6:0]  py;
  logic [2:0]  pcol;
  logic        off;

  assign cur = snap[idx];
  assign px  = cur[14:7];
  assign py  = cur[6:0];
  assign off = ({1'b0, px} >= WL) || ({1'b0, py} >= HL);

  always_comb begin
    case (idx)
      2'd0:    pcol = C1;
      2'd1:    pcol = C2;
      2'd2:    pcol = C3;
      default: pcol = C4;
    endcase
  end

  // Outputs are computed for the state being entered, so each registered
  // output lines up with the state it belongs to.
  always_comb begin
    state_n   = state;
    cx_n      = cx;
    cy_n      = cy;
    clr_end_n = clr_end;
    snap_n    = snap;
    idx_n     = idx;
    wcnt_n    = wcnt;
    addr_n    = ram_address;
    data_n    = ram_data;
    vx_n      = vga_x;
    vy_n      = vga_y;
    col_n     = vga_colour;
    wren_n    = 1'b0;
    plot_n    = 1'b0;
    kill_n    = 4'b0;
    done_n    = 1'b0;
    ovr_n     = overrun;
    next_p    = 1'b0;
    if (tick && state != CLEAR && state != IDLE) ovr_n = 1'b1;
    case (state)
      CLEAR: begin
        if (clr_end) begin
          state_n = IDLE;
        end else begin
          wren_n = 1'b1;
          data_n = 3'b0;
          plot_n = 1'b1;
          col_n  = 3'b0;
          addr_n = {cx, cy};
          vx_n   = cx;
          vy_n   = cy;
          if (cy == 7'(H - 1)) begin
            cy_n = 7'd0;
            if (cx == 8'(W - 1)) clr_end_n = 1'b1;
            else                 cx_n = cx + 8'd1;
          end else begin
            cy_n = cy + 7'd1;
          end
        end
      end
      IDLE: begin
        if (tick) begin
          snap_n  = players;
          idx_n   = 2'd0;
          state_n = SEL;
        end else if (clear_req) begin
          state_n   = CLEAR;
          cx_n      = 8'd0;
          cy_n      = 7'd0;
          clr_end_n = 1'b0;
        end
      end
      SEL: begin
        if (!cur[17]) begin
          next_p = 1'b1;
        end else if (off) begin
          kill_n = 4'b0001 << idx;
          next_p = 1'b1;
        end else begin
          state_n = RD;
          addr_n  = {px, py};
        end
      end
      RD: begin
        if (RD_LAT > 1) begin
          state_n = WAIT;
          wcnt_n  = 8'(RD_LAT - 2);
        end else begin
          state_n = CHK;
        end
      end
      WAIT: begin
        if (wcnt == 8'd0) state_n = CHK;
        else              wcnt_n  = wcnt - 8'd1;
      end
      CHK: begin
        if (ram_q != 3'b0) begin
          kill_n = 4'b0001 << idx;
          next_p = 1'b1;
        end else begin
          state_n = WR;
          wren_n  = 1'b1;
          data_n  = pcol;
          plot_n  = 1'b1;
          vx_n    = px;
          vy_n    = py;
          col_n   = pcol;
        end
      end
      WR:      next_p = 1'b1;
      default: state_n = CLEAR;
    endcase
    if (next_p) begin
      if (idx == 2'd3) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        idx_n   = idx + 2'd1;
        state_n = SEL;
      end
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= CLEAR;
      cx          <= 8'd0;
      cy          <= 7'd0;
      clr_end     <= 1'b0;
      snap        <= '0;
      idx         <= 2'd0;
      wcnt        <= 8'd0;
      ram_address <= 15'd0;
      ram_data    <= 3'd0;
      ram_wren    <= 1'b0;
      vga_x       <= 8'd0;
      vga_y       <= 7'd0;
      vga_colour  <= 3'd0;
      vga_plot    <= 1'b0;
      kill        <= 4'd0;
      busy        <= 1'b1;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      cx          <= cx_n;
      cy          <= cy_n;
      clr_end     <= clr_end_n;
      snap        <= snap_n;
      idx         <= idx_n;
      wcnt        <= wcnt_n;
      ram_address <= addr_n;
      ram_data    <= data_n;
      ram_wren    <= wren_n;
      vga_x       <= vx_n;
      vga_y       <= vy_n;
      vga_colour  <= col_n;
      vga_plot    <= plot_n;
      kill        <= kill_n;
      busy        <= busy_n;
      done        <= done_n;
      overrun     <= ovr_n;
    end
  end

endmodule

// File: tb/tb_turf_painter.sv
// Bench for turf_painter: RAM model with 2-cycle read latency, event logger,
// and a board-level reference model of one tick scan.
module tb_turf_painter;
  localparam int W = 160, H = 120, RDL = 2;

  logic        CLOCK_50 = 1'b0, resetn = 1'b0, tick = 1'b0, clear_req = 1'b0;
  logic [71:0] players = '0;
  logic [14:0] ram_address;
  logic [2:0]  ram_data, ram_q, vga_colour;
  logic        ram_wren, vga_plot, busy, done, overrun;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [3:0]  kill;

  turf_painter dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .tick(tick), .players(players),
    .clear_req(clear_req), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .kill(kill), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [2:0] mem [0:32767];
  logic [2:0] q1;
  always @(posedge CLOCK_50) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    q1    <= mem[ram_address];
    ram_q <= q1;
  end

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int done_cnt = 0, done_cyc = 0;
  int kill_cnt [4];
  logic [14:0] wr_a [$];
  logic [2:0]  wr_d [$];
  logic [7:0]  pl_x [$];
  logic [6:0]  pl_y [$];
  logic [2:0]  pl_c [$];
  logic [14:0] exp_a [$];
  logic [2:0]  exp_d [$];
  logic [2:0]  ref_b [0:159][0:119];

  always @(negedge CLOCK_50) begin
    if (ram_wren) begin wr_a.push_back(ram_address); wr_d.push_back(ram_data); end
    if (vga_plot) begin pl_x.push_back(vga_x); pl_y.push_back(vga_y); pl_c.push_back(vga_colour); end
    if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    for (int i = 0; i < 4; i++) if (kill[i]) kill_cnt[i] = kill_cnt[i] + 1;
  end

  function automatic logic [17:0] rec(bit act, int x, int y);
    return {act, 2'b00, 8'(x), 7'(y)};
  endfunction

  function automatic logic [2:0] colour(int i);
    case (i)
      0: return 3'b100;
      1: return 3'b010;
      2: return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  task automatic flush();
    wr_a.delete(); wr_d.delete(); pl_x.delete(); pl_y.delete(); pl_c.delete();
    exp_a.delete(); exp_d.delete();
    for (int i = 0; i < 4; i++) kill_cnt[i] = 0;
  endtask

  task automatic board_zero();
    for (int x = 0; x < W; x++) for (int y = 0; y < H; y++) ref_b[x][y] = 3'b0;
  endtask

  // Reference: players in order; off-board or occupied heads die, others paint.
  task automatic model_tick(input logic [71:0] p, output int cost, output logic [3:0] km);
    logic [17:0] r;
    int x, y;
    cost = 0; km = 4'b0;
    for (int i = 0; i < 4; i++) begin
      r = p[18*i +: 18];
      x = int'(r[14:7]); y = int'(r[6:0]);
      if (!r[17]) cost += 1;
      else if (x >= W || y >= H) begin km[i] = 1'b1; cost += 1; end
      else if (ref_b[x][y] != 3'b0) begin km[i] = 1'b1; cost += 2 + RDL; end
      else begin
        ref_b[x][y] = colour(i);
        exp_a.push_back({8'(x), 7'(y)});
        exp_d.push_back(colour(i));
        cost += 3 + RDL;
      end
    end
  endtask

  task automatic run_tick(input logic [71:0] p, input bit with_clr,
                          output int lat, output int cost, output logic [3:0] km);
    int d0, t0;
    flush();
    model_tick(p, cost, km);
    d0 = done_cnt;
    @(negedge CLOCK_50); players = p; tick = 1'b1; clear_req = with_clr;
    @(negedge CLOCK_50); tick = 1'b0; clear_req = 1'b0; t0 = cyc;
    for (int k = 0; k < 300 && done_cnt == d0; k++) @(negedge CLOCK_50);
    lat = (done_cnt != d0) ? done_cyc - t0 : -1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    int errs;
    logic [14:0] ea;
    repeat (3) @(negedge CLOCK_50);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    total++; if (ram_wren !== 1'b0 || vga_plot !== 1'b0) begin bad++; $display("FAIL reset_strobes: wren=%b plot=%b want 0", ram_wren, vga_plot); end
    total++; if (kill !== 4'b0 || done !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_flags: kill=%b done=%b ovr=%b want 0", kill, done, overrun); end
    total++; if (ram_address !== 15'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", ram_address); end
    flush();
    resetn = 1'b1;
    for (int k = 0; k < 20500 && busy; k++) @(negedge CLOCK_50);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_end_busy: got %b want 0", busy); end
    total++; if (wr_a.size() != W*H) begin bad++; $display("FAIL clear_count: got %0d want %0d", wr_a.size(), W*H); end
    errs = 0;
    for (int k = 0; k < wr_a.size() && k < W*H; k++) begin
      ea = {8'(k / H), 7'(k % H)};
      if (wr_a[k] !== ea || wr_d[k] !== 3'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL clear_order: got %0d bad writes want 0", errs); end
    errs = 0;
    for (int k = 0; k < pl_c.size(); k++) if (pl_c[k] !== 3'b0) errs++;
    total++; if (pl_c.size() != W*H || errs != 0) begin bad++; $display("FAIL clear_plots: got %0d plots %0d bad want %0d/0", pl_c.size(), errs, W*H); end
    total++; if (done_cnt != 0 || overrun !== 1'b0) begin bad++; $display("FAIL clear_done: got done=%0d ovr=%b want 0/0", done_cnt, overrun); end
    board_zero();
  endtask

  task automatic test_corner();
    int lat, cost;
    logic [3:0] km;
    run_tick({18'h0, 18'h0, rec(1, 0, 0), rec(1, 159, 119)}, 0, lat, cost, km);
    total++; if (lat != 12) begin bad++; $display("FAIL corner_latency: got %0d want 12", lat); end
    total++; if (wr_a.size() != 2) begin bad++; $display("FAIL corner_writes: got %0d want 2", wr_a.size()); end
    else begin
      total++; if (wr_a[0] !== {8'd159, 7'd119} || wr_d[0] !== 3'b100) begin bad++; $display("FAIL corner_w0: got %h/%b want %h/100", wr_a[0], wr_d[0], {8'd159, 7'd119}); end
      total++; if (wr_a[1] !== 15'd0 || wr_d[1] !== 3'b010) begin bad++; $display("FAIL corner_w1: got %h/%b want 0/010", wr_a[1], wr_d[1]); end
    end
    total++; if (pl_x.size() != 2) begin bad++; $display("FAIL corner_plots: got %0d want 2", pl_x.size()); end
    else begin
      total++; if (pl_x[0] !== 8'd159 || pl_y[0] !== 7'd119 || pl_c[0] !== 3'b100 || pl_x[1] !== 8'd0 || pl_y[1] !== 7'd0 || pl_c[1] !== 3'b010) begin
        bad++; $display("FAIL corner_plot_xy: got (%0d,%0d,%b) (%0d,%0d,%b) want (159,119,100) (0,0,010)", pl_x[0], pl_y[0], pl_c[0], pl_x[1], pl_y[1], pl_c[1]); end
    end
    total++; if (kill_cnt[0] + kill_cnt[1] + kill_cnt[2] + kill_cnt[3] != 0) begin bad++; $display("FAIL corner_kill: got %0d pulses want 0", kill_cnt[0] + kill_cnt[1] + kill_cnt[2] + kill_cnt[3]); end
  endtask

  task automatic test_occupied();
    int lat, cost;
    logic [3:0] km;
    run_tick({18'h0, 18'h0, rec(1, 0, 0), rec(1, 159, 119)}, 0, lat, cost, km);
    total++; if (lat != 10) begin bad++; $display("FAIL occ_latency: got %0d want 10", lat); end
    total++; if (wr_a.size() != 0) begin bad++; $display("FAIL occ_writes: got %0d want 0", wr_a.size()); end
    total++; if (kill_cnt[0] != 1 || kill_cnt[1] != 1 || kill_cnt[2] != 0 || kill_cnt[3] != 0) begin
      bad++; $display("FAIL occ_kill: got %0d%0d%0d%0d want 0011 (p4..p1)", kill_cnt[3], kill_cnt[2], kill_cnt[1], kill_cnt[0]); end
  endtask

  task automatic test_same_cell();
    int lat, cost;
    logic [3:0] km;
    run_tick({18'h0, rec(1, 50, 60), 18'h0, rec(1, 50, 60)}, 0, lat, cost, km);
    total++; if (lat != 11) begin bad++; $display("FAIL same_latency: got %0d want 11", lat); end
    total++; if (wr_a.size() != 1 || pl_x.size() != 1) begin bad++; $display("FAIL same_count: got %0d writes %0d plots want 1/1", wr_a.size(), pl_x.size()); end
    total++; if (mem[{8'd50, 7'd60}] !== 3'b100) begin bad++; $display("FAIL same_ram: got %b want 100", mem[{8'd50, 7'd60}]); end
    total++; if (kill_cnt[0] != 0 || kill_cnt[1] != 0 || kill_cnt[2] != 1 || kill_cnt[3] != 0) begin
      bad++; $display("FAIL same_kill: got %0d%0d%0d%0d want 0100", kill_cnt[3], kill_cnt[2], kill_cnt[1], kill_cnt[0]); end
  endtask

  task automatic test_offboard();
    int lat, cost;
    logic [3:0] km;
    run_tick({rec(1, 200, 5), 18'h0, 18'h0, 18'h0}, 0, lat, cost, km);
    total++; if (lat != 4) begin bad++; $display("FAIL off_latency: got %0d want 4", lat); end
    total++; if (wr_a.size() != 0 || kill_cnt[3] != 1) begin bad++; $display("FAIL off_kill: got %0d writes kill4=%0d want 0/1", wr_a.size(), kill_cnt[3]); end
  endtask

  task automatic test_random();
    int lat, cost, errs;
    logic [3:0] km;
    logic [71:0] p;
    logic [14:0] ea;
    int unsigned sel, x, y;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 4; i++) begin
        sel = $urandom_range(0, 9);
        x = (sel == 0) ? $urandom_range(160, 255) : $urandom_range(0, 7);
        y = (sel == 1) ? $urandom_range(120, 127) : $urandom_range(0, 7);
        p[18*i +: 18] = rec($urandom_range(0, 3) != 0, int'(x), int'(y));
      end
      run_tick(p, 0, lat, cost, km);
      total++; if (lat != cost) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", t, lat, cost); end
      errs = 0;
      if (wr_a.size() != exp_a.size() || pl_x.size() != exp_a.size()) errs++;
      else for (int k = 0; k < exp_a.size(); k++) begin
        ea = exp_a[k];
        if (wr_a[k] !== ea || wr_d[k] !== exp_d[k] || pl_x[k] !== ea[14:7] || pl_y[k] !== ea[6:0] || pl_c[k] !== exp_d[k]) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL rnd_paint[%0d]: got %0d writes %0d bad want %0d writes", t, wr_a.size(), errs, exp_a.size()); end
      errs = 0;
      for (int i = 0; i < 4; i++) if (kill_cnt[i] != int'(km[i])) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL rnd_kill[%0d]: got %0d%0d%0d%0d want %b", t, kill_cnt[3], kill_cnt[2], kill_cnt[1], kill_cnt[0], km); end
    end
  endtask

  task automatic test_clear_req();
    int d0, errs;
    flush();
    d0 = done_cnt;
    @(negedge CLOCK_50); clear_req = 1'b1;
    @(negedge CLOCK_50); clear_req = 1'b0;
    for (int k = 0; k < 20500 && busy; k++) @(negedge CLOCK_50);
    errs = 0;
    for (int k = 0; k < wr_d.size(); k++) if (wr_d[k] !== 3'b0) errs++;
    total++; if (wr_a.size() != W*H || errs != 0 || busy !== 1'b0) begin bad++; $display("FAIL clrreq_writes: got %0d (%0d nonzero) busy=%b want %0d/0/0", wr_a.size(), errs, busy, W*H); end
    total++; if (done_cnt != d0) begin bad++; $display("FAIL clrreq_done: got %0d want %0d", done_cnt, d0); end
    board_zero();
  endtask

  task automatic test_tick_vs_clear();
    int lat, cost;
    logic [3:0] km;
    run_tick({18'h0, 18'h0, 18'h0, rec(1, 3, 3)}, 1, lat, cost, km);
    total++; if (lat != cost || wr_a.size() != 1) begin bad++; $display("FAIL tickclr_scan: got lat=%0d writes=%0d want %0d/1", lat, wr_a.size(), cost); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tickclr_busy: got %b want 0", busy); end
  endtask

  task automatic test_overrun();
    int cost, d0;
    logic [3:0] km;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_initial: got %b want 0", overrun); end
    flush();
    model_tick({18'h0, 18'h0, rec(1, 81, 81), rec(1, 80, 80)}, cost, km);
    d0 = done_cnt;
    @(negedge CLOCK_50); players = {18'h0, 18'h0, rec(1, 81, 81), rec(1, 80, 80)}; tick = 1'b1;
    @(negedge CLOCK_50); tick = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    tick = 1'b1;
    @(negedge CLOCK_50); tick = 1'b0;
    for (int k = 0; k < 300 && done_cnt == d0; k++) @(negedge CLOCK_50);
    repeat (20) @(negedge CLOCK_50);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ovr_done: got %0d want 1", done_cnt - d0); end
    total++; if (wr_a.size() != exp_a.size()) begin bad++; $display("FAIL ovr_writes: got %0d want %0d", wr_a.size(), exp_a.size()); end
  endtask

  task automatic test_reset_midscan();
    int lat, cost;
    bit seen;
    logic [3:0] km;
    seen = 0;
    @(negedge CLOCK_50); players = {18'h0, 18'h0, 18'h0, rec(1, 90, 90)}; tick = 1'b1;
    @(negedge CLOCK_50); tick = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (ram_wren) seen = 1; else @(negedge CLOCK_50);
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_reach_wr: got no write want one"); end
    #2 resetn = 1'b0;
    #1;
    total++; if (ram_wren !== 1'b0 || busy !== 1'b1 || overrun !== 1'b0) begin bad++; $display("FAIL mid_abort: got wren=%b busy=%b ovr=%b want 0/1/0", ram_wren, busy, overrun); end
    @(negedge CLOCK_50);
    flush();
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    for (int k = 0; k < 20500 && busy; k++) @(negedge CLOCK_50);
    total++; if (wr_a.size() != W*H || busy !== 1'b0) begin bad++; $display("FAIL mid_clear: got %0d writes busy=%b want %0d/0", wr_a.size(), busy, W*H); end
    board_zero();
    run_tick({18'h0, 18'h0, 18'h0, rec(1, 90, 90)}, 0, lat, cost, km);
    total++; if (lat != 8 || wr_a.size() != 1) begin bad++; $display("FAIL mid_repaint: got lat=%0d writes=%0d want 8/1", lat, wr_a.size()); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom_range(1, 7));
    for (int i = 0; i < 4; i++) kill_cnt[i] = 0;
    test_reset();
    test_corner();
    test_occupied();
    test_same_cell();
    test_offboard();
    test_random();
    test_clear_req();
    test_tick_vs_clear();
    test_overrun();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
